// File: rtl/pipeline_adder_64_if.sv
// Operand/result handshake bundle for pipeline_adder_64.
// The master side presents operands and consumes results.
interface pipeline_adder_64_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/pipeline_adder_64.sv
// Carry-pipelined adder: each stage ripple-adds one CW-bit chunk and hands its
// carry, the partial sum and the untouched upper operand chunks to the next stage.
module pipeline_adder_64 #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input logic                clk,
  input logic                rst,
  pipeline_adder_64_if.slave bus
);
  localparam int CW = WIDTH / STAGES;
  localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CW{1'b1}});

  logic [STAGES-1:0]            valid_q, valid_d;
  logic [STAGES-1:0]            carry_q, carry_d;
  logic [STAGES-1:0][WIDTH-1:0] sum_q, sum_d;
  logic [STAGES-1:0][WIDTH-1:0] a_q, a_d;
  logic [STAGES-1:0][WIDTH-1:0] b_q, b_d;

  logic [STAGES-1:0]            src_valid;
  logic [STAGES-1:0]            src_carry;
  logic [STAGES-1:0][WIDTH-1:0] src_sum;
  logic [STAGES-1:0][WIDTH-1:0] src_a;
  logic [STAGES-1:0][WIDTH-1:0] src_b;
  logic [STAGES-1:0][WIDTH-1:0] add_sum;
  logic [STAGES-1:0]            add_carry;

  logic out_valid;
  logic in_ready;
  logic unused_tail;

  // out_valid is masked during reset so in_ready reads 1 before the clearing edge.
  assign out_valid     = valid_q[STAGES-1] & ~rst;
  assign in_ready      = bus.out_ready | ~out_valid;
  assign bus.out_valid = out_valid;
  assign bus.in_ready  = in_ready;
  assign bus.sum       = sum_q[STAGES-1];
  assign bus.cout      = carry_q[STAGES-1];
  assign unused_tail   = ^{a_q[STAGES-1], b_q[STAGES-1]};

  always_comb begin
    src_valid[0] = bus.in_valid;
    src_carry[0] = bus.cin;
    src_sum[0]   = '0;
    src_a[0]     = bus.a;
    src_b[0]     = bus.b;
    for (int k = 1; k < STAGES; k++) begin
      src_valid[k] = valid_q[k-1];
      src_carry[k] = carry_q[k-1];
      src_sum[k]   = sum_q[k-1];
      src_a[k]     = a_q[k-1];
      src_b[k]     = b_q[k-1];
    end
  end

  always_comb begin
    logic c;
    c         = 1'b0;
    add_sum   = src_sum;
    add_carry = '0;
    for (int k = 0; k < STAGES; k++) begin
      c = src_carry[k];
      for (int i = 0; i < CW; i++) begin
        add_sum[k][k*CW+i] = src_a[k][k*CW+i] ^ src_b[k][k*CW+i] ^ c;
        c = (src_a[k][k*CW+i] & src_b[k][k*CW+i]) |
            (c & (src_a[k][k*CW+i] ^ src_b[k][k*CW+i]));
      end
      add_carry[k] = c;
    end
  end

  // Whole pipeline moves as one; a stalled output freezes every stage.
  always_comb begin
    valid_d = valid_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    a_d     = a_q;
    b_d     = b_q;
    if (in_ready) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_d[k] = src_valid[k];
        carry_d[k] = add_carry[k];
        sum_d[k]   = add_sum[k];
        a_d[k]     = src_a[k] & ~(CHUNK_MASK << (k*CW));
        b_d[k]     = src_b[k] & ~(CHUNK_MASK << (k*CW));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      carry_q <= '0;
      sum_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end
endmodule

// File: tb/tb_pipeline_adder_64.sv
// Directed-plus-random bench for pipeline_adder_64 against a delay-line model of
// exact (a + b + cin) results.
module tb_pipeline_adder_64;
  localparam int W = 64;
  localparam int S = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pipeline_adder_64_if #(.WIDTH(W)) bus ();

  pipeline_adder_64 #(.WIDTH(W), .STAGES(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic       mv [S];
  logic [W:0] mr [S];
  int vectors;
  int miscompares;
  int n_checks;
  int seen_valid;
  logic [W-1:0] ra;
  logic [W-1:0] rb;
  logic [W-1:0] ones;

  task automatic checkOutput(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check in_ready, advance model, check outputs.
  task automatic applyStimulus(input logic r, input logic v, input logic [W-1:0] av,
                               input logic [W-1:0] bv, input logic c, input logic ordy);
    logic       exp_ready;
    logic [W:0] res;
    rst           = r;
    bus.in_valid  = v;
    bus.a         = av;
    bus.b         = bv;
    bus.cin       = c;
    bus.out_ready = ordy;
    #1;
    exp_ready = r | ordy | ~mv[S-1];
    checkOutput("in_ready", {{W{1'b0}}, bus.in_ready}, {{W{1'b0}}, exp_ready});
    @(posedge clk);
    res = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, c};
    if (r) begin
      for (int k = 0; k < S; k++) begin
        mv[k] = 1'b0;
        mr[k] = '0;
      end
    end else if (exp_ready) begin
      for (int k = S-1; k > 0; k--) begin
        mv[k] = mv[k-1];
        mr[k] = mr[k-1];
      end
      mv[0] = v;
      mr[0] = res;
    end
    #1;
    if (bus.out_valid === 1'b1) seen_valid++;
    checkOutput("out_valid", {{W{1'b0}}, bus.out_valid}, {{W{1'b0}}, mv[S-1]});
    if (mv[S-1] || r) checkOutput("cout_sum", {bus.cout, bus.sum}, mr[S-1]);
    vectors++;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    n_checks    = 0;
    seen_valid  = 0;
    ones        = '1;
    for (int k = 0; k < S; k++) begin
      mv[k] = 1'b0;
      mr[k] = '0;
    end
    $display("[TB] start");

    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 64'd3, 64'd4, 1'b0, 1'b1);

    $display("[TB] single add");
    applyStimulus(1'b0, 1'b1, 64'd1, 64'd1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);

    $display("[TB] full carry chain and maximum operands");
    applyStimulus(1'b0, 1'b1, ones, '0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, ones, ones, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);

    $display("[TB] streaming");
    seen_valid = 0;
    for (int i = 0; i < 100; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      applyStimulus(1'b0, 1'b1, ra, rb, 1'($urandom_range(0, 1)), 1'b1);
    end
    for (int i = 0; i < S; i++) applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    checkOutput("stream_count", (W+1)'(seen_valid), (W+1)'(100));

    $display("[TB] backpressure");
    for (int i = 0; i < S; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      applyStimulus(1'b0, 1'b1, ra, rb, 1'($urandom_range(0, 1)), 1'b1);
    end
    for (int i = 0; i < 5; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      applyStimulus(1'b0, 1'b1, ra, rb, 1'b1, 1'b0);
    end
    for (int i = 0; i < S + 2; i++) applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);

    $display("[TB] reset mid-flight");
    for (int i = 0; i < 3; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      applyStimulus(1'b0, 1'b1, ra, rb, 1'b0, 1'b1);
    end
    applyStimulus(1'b1, 1'b1, 64'd100, 64'd200, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 64'd5, 64'd7, 1'b0, 1'b1);
    for (int i = 0; i < S + 2; i++) applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);

    $display("[TB] %0d comparisons made", n_checks);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pipeline_adder_64.md
PIPELINE_ADDER_64 -- requirements
Module: pipeline_adder_64

Interface
REQ-001 The module SHALL have parameter WIDTH, default 64, giving the operand and sum width in bits.
REQ-002 The module SHALL have parameter STAGES, default 4, giving the register stage count; WIDTH SHALL be an integer multiple of STAGES, with chunk width CW = WIDTH/STAGES.
REQ-003 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  is the reset, synchronous and active-high.
REQ-005 Port in_valid  input  1  means operands a, b and cin are presented.
REQ-006 Port in_ready  output  1  means the block accepts operands this cycle.
REQ-007 Port a  input  WIDTH  is addend A, unsigned.
REQ-008 Port b  input  WIDTH  is addend B, unsigned.
REQ-009 Port cin  input  1  is the carry-in to bit 0.
REQ-010 Port out_valid  output  1  means sum and cout hold a completed result.
REQ-011 Port out_ready  input  1  means the consumer takes the result this cycle.
REQ-012 Port sum  output  WIDTH  is the registered result, equal to (a + b + cin) mod 2^WIDTH.
REQ-013 Port cout  output  1  is the registered carry-out of bit WIDTH-1.

Function
REQ-014 Stage k (k = 0..STAGES-1) SHALL add chunk k, bits [k*CW +: CW] of a and b, plus the carry registered by stage k-1 (cin for stage 0), using a CW-bit ripple-carry adder.
REQ-015 Each stage register SHALL hold a valid bit, the sum chunks completed so far, the carry-out of its chunk, and the not-yet-added upper chunks of a and b.
REQ-016 A transfer SHALL occur on a rising edge when in_valid and in_ready are both 1.
REQ-017 in_ready SHALL equal out_ready OR NOT out_valid, combinationally.
REQ-018 All stages SHALL advance together when in_ready is 1 and SHALL all hold their contents when in_ready is 0.
REQ-019 When the pipeline advances without a transfer, a bubble (valid = 0) SHALL enter stage 0.
REQ-020 Latency SHALL be exactly STAGES rising edges: with the accepting edge counted as edge 1, the result SHALL appear on sum, cout and out_valid after edge STAGES.
REQ-021 Throughput SHALL be one result per cycle while out_ready is held at 1.
REQ-022 While out_valid = 1 and out_ready = 0, sum, cout and out_valid SHALL stay stable, and no input SHALL be accepted.
REQ-023 Results SHALL leave in acceptance order, with no loss and no duplication.
REQ-024 Arithmetic wrap-around SHALL be modular: a carry out of the top bit sets cout and is not reflected in sum.
REQ-025 Bubbles SHALL never raise out_valid; data in bubble stages is don't-care but SHALL NOT reach out_valid = 1.

Reset
REQ-026 While rst = 1 at a rising edge, every stage valid bit SHALL clear to 0, out_valid SHALL read 0, and sum and cout SHALL clear to 0.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight operands; no pre-reset result SHALL ever appear afterward.
REQ-028 While rst = 1, in_ready SHALL read 1 (out_valid = 0), but no transfer occurring during reset SHALL be retained.
REQ-029 After rst deasserts, the first accepted operand SHALL emerge with the normal STAGES-edge latency.

Verification
REQ-030 Single add: a = 1, b = 1, cin = 0, out_ready = 1 -> out_valid rises after edge 4; sum = 2, cout = 0; out_valid is 0 on the following cycle.
REQ-031 Full carry chain: a = 64'hFFFF_FFFF_FFFF_FFFF, b = 0, cin = 1 -> sum = 0, cout = 1; this crosses all four stage boundaries.
REQ-032 Maximum operands: a = b = all-ones, cin = 1 -> sum = all-ones, cout = 1.
REQ-033 Streaming: the bench applies 100 back-to-back random transfers with out_ready = 1 -> it sees 100 results on consecutive cycles, each matching the reference model, in order.
REQ-034 Backpressure: out_ready is held 0 for 5 cycles with results in flight -> sum and cout stay stable and in_ready = 0; on release, all results drain in order with none lost or duplicated.
REQ-035 Reset mid-flight: the bench accepts 3 operands, asserts rst for 1 cycle, then accepts a = 5, b = 7 -> only sum = 12 ever appears after reset.
